hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the stall and flush controls of the IF/ID and ID/EX registers and the PC. It also produces the ID-stage forwarding selects that ID/EX latches alongside the instruction. It consumes the ID/EX and EX/MEM stage outputs and detects three conditions: load-use hazards, taken redirects resolved in EX, and the halt syscall. A small FSM freezes the pipeline on halt until an external go. Optional performance counters track cycles, stalls and flushes.

## Interface
Parameters:
- none

Ports (clock and reset first):
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- go  in  1  resume request; level input, rising edge detected internally.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_use_rs  in  1  ID instruction reads rs.
- ID_use_rt  in  1  ID instruction reads rt.
- EX_Effective  in  1  EX slot holds a valid instruction.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemToReg  in  1  EX instruction is a load.
- EX_Rd_no  in  5  EX destination register.
- EX_taken  in  1  EX resolved a taken branch, JMP, JAL or JR.
- EX_Syscall  in  1  EX instruction is a syscall.
- EX_halt  in  1  EX syscall service is halt ($v0 == 10).
- MEM_Effective  in  1  MEM slot holds a valid instruction.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- MEM_Rd_no  in  5  MEM destination register.
- PC_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold IF/ID.
- IF_ID_flush  out  1  zero IF/ID.
- ID_EX_stall  out  1  drives ID/EX Enable (1 = hold).
- ID_EX_flush  out  1  drives ID/EX rst (1 = insert bubble).
- R1_forward  out  2  rs source select for ID/EX.
- R2_forward  out  2  rt source select for ID/EX.
- halted  out  1  FSM is in HALT.
- cycle_cnt  out  32  count of RUN cycles.
- stall_cnt  out  32  count of load-use stall cycles.
- flush_cnt  out  32  count of redirect flush cycles.

## Operation
- State: FSM {RUN, HALT}, go_q (registered go), and the three counters.
- Forward code meaning: 2'b00 = register file; 2'b01 = result of the instruction now in EX; 2'b10 = result of the instruction now in MEM; 2'b11 is never driven.
- Forward match rule: a stage matches when it is Effective, has RegWrite set, its Rd_no is nonzero, Rd_no equals the source field, and the ID instruction uses that source.
- Forward priority: EX over MEM. No match → 00. Register 0 is never forwarded.
- Load-use hazard: EX_MemToReg is set and the EX stage matches rs or rt.
- Load-use response: PC_stall = IF_ID_stall = ID_EX_flush = 1 for exactly one cycle. The load then leaves EX and the hazard re-evaluates to the MEM forward (10).
- Redirect: EX_taken & EX_Effective → IF_ID_flush = ID_EX_flush = 1; stalls 0.
- Halt detect (RUN only): EX_Syscall & EX_halt & EX_Effective.
  - In the detect cycle: PC_stall = IF_ID_stall = ID_EX_flush = 1, so the syscall drains behind a bubble.
  - Next state HALT.
- HALT: PC_stall = IF_ID_stall = ID_EX_stall = 1; all flushes 0; halted = 1. Exit to RUN on go & !go_q.
- Priority in RUN: halt detect > redirect > load-use. A redirect coincident with a load-use hazard flushes; no stall is taken or counted.
- Counters:
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each redirect cycle.
  - All three wrap modulo 2^32 and freeze in HALT.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and state. They take effect at the next posedge of the controlled registers.
- halted is a direct decode of the registered state.
- Reset (rst = 1 at posedge):
  - state = RUN, go_q = 0, counters = 0.
  - While rst is high: IF_ID_flush = ID_EX_flush = 1, all stalls 0, forwards 00, halted 0.
- Reset during HALT returns to RUN on the same edge.
- go held high across HALT entry does not resume; a fresh 0→1 edge is required.
- go edge and a new halt detect in the same cycle cannot coincide: detect is only evaluated in RUN.
- Latencies:
  - Load-use bubble: 1 cycle.
  - Redirect penalty: 2 cycles.
  - Resume: first unstalled cycle is the one after the go edge is sampled.

## Configuration
- HAZARD_STATS_EN defined: the three counters and their increment logic are compiled in.
- HAZARD_STATS_EN undefined: cycle_cnt, stall_cnt and flush_cnt are tied to 0 with no counter registers. All other behaviour is identical.

## Test plan
- Load-use: EX = lw $8 (EX_MemToReg = 1, Rd = 8); ID reads rs = 8.
  - Cycle 1: PC_stall = IF_ID_stall = ID_EX_flush = 1.
  - Cycle 2: no stall, R1_forward = 10; stall_cnt = 1.
- ALU forwarding: EX writes $5 and MEM writes $5; ID rs = rt = 5 → R1_forward = R2_forward = 01, no stall. With EX_Rd_no = 0 instead → forwards 10.
- Redirect plus load-use same cycle: EX_taken = 1 with a matching lw hazard → IF_ID_flush = ID_EX_flush = 1, PC_stall = 0; flush_cnt += 1, stall_cnt unchanged.
- Halt: EX syscall with EX_halt = 1.
  - Detect cycle: ID_EX_flush = 1.
  - Then halted = 1 with all stalls high for 20 cycles; cycle_cnt is frozen.
  - go 0→1 → RUN on the next cycle.
- Reset mid-HALT: assert rst in HALT → halted = 0 and counters = 0 at the next edge; flushes are 1 while rst is held.
- Wrap, with HAZARD_STATS_EN: preload cycle_cnt to 32'hFFFFFFFF (force), run 1 cycle → 0. Without the macro: all counters read 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. Drives the stall/flush controls of the PC, IF/ID
// and ID/EX registers and the ID-stage forwarding selects that ID/EX latches
// with the instruction. Detects load-use hazards, taken redirects resolved in
// EX and the halt syscall; a two-state FSM freezes the pipeline on halt until
// a fresh rising edge on go.
//
// Optional feature: define HAZARD_STATS_EN to compile in the cycle/stall/flush
// performance counters. Without it the counter outputs are tied to zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go                resume request (level; rising edge detected here)
//   ID_rs/ID_rt       source fields of the ID instruction, with use flags
//   EX_*              EX stage status (valid, write, load, dest, taken, halt)
//   MEM_*             MEM stage status (valid, write, dest)
//   PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush
//                     pipeline register controls (combinational)
//   R1_forward/R2_forward  00 regfile, 01 EX result, 10 MEM result
//   halted            FSM is in HALT
//   cycle_cnt, stall_cnt, flush_cnt   performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        EX_Effective,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic [4:0]  EX_Rd_no,
    input  logic        EX_taken,
    input  logic        EX_Syscall,
    input  logic        EX_halt,
    input  logic        MEM_Effective,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_Rd_no,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_stall,
    output logic        ID_EX_flush,
    output logic [1:0]  R1_forward,
    output logic [1:0]  R2_forward,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   go_q;
    logic   go_rise;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, redirect, halt_det;

    // EX has priority over MEM; no hit selects the register file.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return 2'b01;
        else if (mem_hit)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign go_rise = go & ~go_q;

    // Register 0 is hardwired, so a nonzero destination is part of every match.
    assign ex_hit_rs  = EX_Effective & EX_RegWrite & (EX_Rd_no != 5'd0)
                        & (EX_Rd_no == ID_rs) & ID_use_rs;
    assign ex_hit_rt  = EX_Effective & EX_RegWrite & (EX_Rd_no != 5'd0)
                        & (EX_Rd_no == ID_rt) & ID_use_rt;
    assign mem_hit_rs = MEM_Effective & MEM_RegWrite & (MEM_Rd_no != 5'd0)
                        & (MEM_Rd_no == ID_rs) & ID_use_rs;
    assign mem_hit_rt = MEM_Effective & MEM_RegWrite & (MEM_Rd_no != 5'd0)
                        & (MEM_Rd_no == ID_rt) & ID_use_rt;

    assign load_use = EX_MemToReg & (ex_hit_rs | ex_hit_rt);
    assign redirect = EX_taken & EX_Effective;
    assign halt_det = EX_Syscall & EX_halt & EX_Effective;

    always_comb begin
        state_d     = state_q;
        PC_stall    = 1'b0;
        IF_ID_stall = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_stall = 1'b0;
        ID_EX_flush = 1'b0;
        R1_forward  = 2'b00;
        R2_forward  = 2'b00;
        halted      = 1'b0;

        if (rst) begin
            // Hold both pipeline registers empty while reset is asserted.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else begin
            R1_forward = fwd_sel(ex_hit_rs, mem_hit_rs);
            R2_forward = fwd_sel(ex_hit_rt, mem_hit_rt);
            case (state_q)
                RUN: begin
                    if (halt_det) begin
                        // Freeze fetch and let the syscall drain behind a bubble.
                        PC_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                        state_d     = HALT;
                    end else if (redirect) begin
                        // A redirect squashes the ID instruction, so any load-use
                        // hazard it carries is moot.
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                    end
                end
                HALT: begin
                    PC_stall    = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_stall = 1'b1;
                    halted      = 1'b1;
                    if (go_rise)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // ---- state register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go;
        end
    end

`ifdef HAZARD_STATS_EN
    logic        run_cyc;
    logic        stall_evt;
    logic        flush_evt;
    logic [31:0] cycle_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign run_cyc   = (state_q == RUN);
    assign stall_evt = run_cyc & ~halt_det & ~redirect & load_use;
    assign flush_evt = run_cyc & ~halt_det & redirect;

    // ---- counter register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (run_cyc) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (stall_evt)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign cycle_cnt = 32'd0;
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. A behavioural model (halted flag, previous
// go, counters) predicts every output from the current inputs; one compare
// process checks all outputs on every falling edge, and the stimulus sequence
// adds hand-computed literal expectations at the interesting points.
// Control vector layout: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
// ID_EX_flush, R1_forward[1:0], R2_forward[1:0], halted}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go;
    logic [4:0]  ID_rs, ID_rt, EX_Rd_no, MEM_Rd_no;
    logic        ID_use_rs, ID_use_rt;
    logic        EX_Effective, EX_RegWrite, EX_MemToReg, EX_taken, EX_Syscall, EX_halt;
    logic        MEM_Effective, MEM_RegWrite;
    logic        PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic [1:0]  R1_forward, R2_forward;
    logic        halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [9:0]  ctl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .go(go),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .EX_Effective(EX_Effective), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
        .EX_Rd_no(EX_Rd_no), .EX_taken(EX_taken), .EX_Syscall(EX_Syscall), .EX_halt(EX_halt),
        .MEM_Effective(MEM_Effective), .MEM_RegWrite(MEM_RegWrite), .MEM_Rd_no(MEM_Rd_no),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
        .R1_forward(R1_forward), .R2_forward(R2_forward), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                  R1_forward, R2_forward, halted};

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_halt = 1'b0;
    bit          m_goq  = 1'b0;
    logic [31:0] m_cyc  = '0, m_st = '0, m_fl = '0;
    logic [31:0] cyc_adj = '0;   // offset applied when the counter is preloaded

    function automatic logic [1:0] exp_fwd(input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return 2'b00;
        if (EX_Effective && EX_RegWrite && EX_Rd_no == src) return 2'b01;
        if (MEM_Effective && MEM_RegWrite && MEM_Rd_no == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ev_halt();
        return EX_Syscall && EX_halt && EX_Effective;
    endfunction

    function automatic bit ev_redir();
        return EX_taken && EX_Effective;
    endfunction

    function automatic bit ev_lu();
        return EX_MemToReg && (exp_fwd(ID_rs, ID_use_rs) == 2'b01 ||
                               exp_fwd(ID_rt, ID_use_rt) == 2'b01);
    endfunction

    function automatic logic [9:0] exp_ctl();
        logic [1:0] f1, f2;
        f1 = exp_fwd(ID_rs, ID_use_rs);
        f2 = exp_fwd(ID_rt, ID_use_rt);
        if (rst)        return 10'b0010100000;
        if (m_halt)     return {5'b11010, f1, f2, 1'b1};
        if (ev_halt())  return {5'b11001, f1, f2, 1'b0};
        if (ev_redir()) return {5'b00101, f1, f2, 1'b0};
        if (ev_lu())    return {5'b11001, f1, f2, 1'b0};
        return {5'b00000, f1, f2, 1'b0};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_halt = 1'b0;
            m_goq  = 1'b0;
            m_cyc  = '0;
            m_st   = '0;
            m_fl   = '0;
        end else begin
            if (!m_halt) begin
                m_cyc = m_cyc + 32'd1;
                if (ev_halt())       m_halt = 1'b1;
                else if (ev_redir()) m_fl = m_fl + 32'd1;
                else if (ev_lu())    m_st = m_st + 32'd1;
            end else if (go && !m_goq) begin
                m_halt = 1'b0;
            end
            m_goq = go;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("ctl", {22'd0, ctl}, {22'd0, exp_ctl()});
        check("cycle_cnt", cycle_cnt, STATS ? m_cyc + cyc_adj : 32'd0);
        check("stall_cnt", stall_cnt, STATS ? m_st : 32'd0);
        check("flush_cnt", flush_cnt, STATS ? m_fl : 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
        EX_Effective = 0; EX_RegWrite = 0; EX_MemToReg = 0; EX_Rd_no = 0;
        EX_taken = 0; EX_Syscall = 0; EX_halt = 0;
        MEM_Effective = 0; MEM_RegWrite = 0; MEM_Rd_no = 0;
    endtask

    task automatic lit(input string nm, input logic [9:0] exp);
        @(negedge clk);
        check(nm, {22'd0, ctl}, {22'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; go = 1'b0;
        clear_in();
        tick(); tick();
        lit("reset_ctl", 10'b0010100000);
        check("reset_cycle_cnt", cycle_cnt, 32'd0);
        tick();
        rst = 1'b0;

        // Load-use: EX = lw $8, ID reads rs = 8
        EX_Effective = 1; EX_RegWrite = 1; EX_MemToReg = 1; EX_Rd_no = 8;
        ID_rs = 8; ID_use_rs = 1;
        lit("lu_stall", 10'b1100101000);
        tick();
        EX_Effective = 0; EX_RegWrite = 0; EX_MemToReg = 0; EX_Rd_no = 0;
        MEM_Effective = 1; MEM_RegWrite = 1; MEM_Rd_no = 8;
        lit("lu_mem_fwd", 10'b0000010000);
        check("lu_stall_cnt", stall_cnt, STATS ? 32'd1 : 32'd0);

        // ALU forwarding, EX over MEM, then EX dest 0 falls back to MEM
        tick(); clear_in();
        EX_Effective = 1; EX_RegWrite = 1; EX_Rd_no = 5;
        MEM_Effective = 1; MEM_RegWrite = 1; MEM_Rd_no = 5;
        ID_rs = 5; ID_rt = 5; ID_use_rs = 1; ID_use_rt = 1;
        lit("alu_ex_fwd", 10'b0000001010);
        tick();
        EX_Rd_no = 0;
        lit("alu_mem_fwd", 10'b0000010100);

        // Register 0 never forwarded; unused source never forwarded
        tick(); clear_in();
        EX_Effective = 1; EX_RegWrite = 1; EX_Rd_no = 0;
        MEM_Effective = 1; MEM_RegWrite = 1; MEM_Rd_no = 0;
        ID_use_rs = 1;
        lit("r0_no_fwd", 10'b0000000000);
        tick(); clear_in();
        EX_Effective = 1; EX_RegWrite = 1; EX_Rd_no = 9;
        ID_rs = 9; ID_rt = 9; ID_use_rt = 1;
        lit("use_gate", 10'b0000000010);

        // Redirect coincident with load-use: flush wins, no stall counted
        tick(); clear_in();
        EX_Effective = 1; EX_RegWrite = 1; EX_MemToReg = 1; EX_Rd_no = 8; EX_taken = 1;
        ID_rs = 8; ID_use_rs = 1;
        lit("redir_lu", 10'b0010101000);
        tick(); clear_in();
        lit("idle", 10'b0000000000);
        check("redir_flush_cnt", flush_cnt, STATS ? 32'd1 : 32'd0);
        check("redir_stall_cnt", stall_cnt, STATS ? 32'd1 : 32'd0);

        // Halt with go already high: entering HALT must not resume
        tick();
        go = 1'b1;
        EX_Effective = 1; EX_Syscall = 1; EX_halt = 1;
        lit("halt_detect", 10'b1100100000);
        tick(); clear_in();
        for (int i = 0; i < 20; i++) begin
            lit("halt_hold", 10'b1101000001);
            tick();
        end
        go = 1'b0;
        lit("halt_go_low", 10'b1101000001);
        tick();
        go = 1'b1;
        lit("halt_go_edge", 10'b1101000001);
        tick();
        lit("resumed", 10'b0000000000);

        // Reset while halted
        tick();
        go = 1'b0;
        EX_Effective = 1; EX_Syscall = 1; EX_halt = 1;
        tick(); clear_in();
        lit("halt2", 10'b1101000001);
        tick();
        rst = 1'b1;
        lit("rst_in_halt", 10'b0010100000);
        tick();
        lit("rst_held", 10'b0010100000);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        tick();
        rst = 1'b0;
        lit("post_rst_run", 10'b0000000000);

`ifdef HAZARD_STATS_EN
        // Counter wrap
        tick();
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        cyc_adj = 32'hFFFF_FFFF - m_cyc;
        #1;
        release dut.cycle_cnt_q;
        @(negedge clk);
        check("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        check("wrap_zero", cycle_cnt, 32'd0);
`else
        tick();
        @(negedge clk);
        check("cnt_tied_cycle", cycle_cnt, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
